// File: rtl/core_pkg.sv
// Shared core constants and types used by the fetch stage and its skid buffer.
package core_pkg;

   localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks the in-flight fetch while the decoder stalls.
module fetch_skid
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] load_insn,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic [31:0] q_insn,
   output logic [31:0] q_pc
);

   fetch_entry_t entry_r;
   logic         valid_r;

   // Entry storage; clear wins over load so a redirect always empties the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= 1'b0;
         entry_r <= '{insn: NOP_INSN, pc: 32'h0000_0000};
      end else if (clear) begin
         valid_r <= 1'b0;
         entry_r <= entry_r;
      end else if (load) begin
         valid_r <= 1'b1;
         entry_r <= '{insn: load_insn, pc: load_pc};
      end else begin
         valid_r <= valid_r;
         entry_r <= entry_r;
      end
   end

   assign valid  = valid_r;
   assign q_insn = entry_r.insn;
   assign q_pc   = entry_r.pc;

endmodule

// File: rtl/fetch_unit_chk.sv
// Invariant checks for the fetch stage: the skid buffer must never be asked to hold a second entry.
module fetch_unit_chk (
   input logic clk,
   input logic reset,
   input logic skid_valid,
   input logic inflight,
   input logic stall
);

   skid_overflow_a: assert property (@(posedge clk) disable iff (reset)
      !(skid_valid && inflight && stall));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, reads a 1-cycle synchronous imem and feeds the decoder.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          IMEM_ADDR_W = 14
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run_en,
   input  logic                   stall,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   output logic                   imem_re,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic [31:0]            imem_rdata,
   output logic [31:0]            insn,
   output logic [31:0]            pc,
   output logic                   run
);

   logic [31:0] fetch_pc_r;
   logic [31:0] inflight_pc_r;
   logic        inflight_r;
   logic        issue_s;
   logic        skid_load_s;
   logic        skid_clear_s;
   logic        skid_valid_s;
   logic [31:0] skid_insn_s;
   logic [31:0] skid_pc_s;

   // Issue and skid control; a redirect cycle never issues so the wrong path is never read.
   always_comb begin
      issue_s      = run_en && !stall && !reset && !redirect;
      skid_load_s  = 1'b0;
      skid_clear_s = 1'b0;
      if (reset || redirect) begin
         skid_clear_s = 1'b1;
      end else if (!stall) begin
         skid_clear_s = skid_valid_s;
      end else begin
         skid_load_s = inflight_r && !skid_valid_s;
      end
   end

   assign imem_re   = issue_s;
   assign imem_addr = fetch_pc_r[IMEM_ADDR_W+1:2];

   // Fetch PC, in-flight tracking and the decoder-facing output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_r    <= RESET_PC;
         inflight_r    <= 1'b0;
         inflight_pc_r <= 32'h0000_0000;
         insn          <= NOP_INSN;
         pc            <= 32'h0000_0000;
         run           <= 1'b0;
      end else if (redirect) begin
         fetch_pc_r    <= word_align(redirect_pc);
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
         insn          <= NOP_INSN;
         pc            <= pc;
         run           <= 1'b0;
      end else begin
         if (issue_s) begin
            fetch_pc_r    <= fetch_pc_r + 32'd4;
            inflight_pc_r <= fetch_pc_r;
            inflight_r    <= 1'b1;
         end else begin
            fetch_pc_r    <= fetch_pc_r;
            inflight_pc_r <= inflight_pc_r;
            inflight_r    <= 1'b0;
         end
         // Skid entry is older than any read in flight, so it drains first.
         if (stall) begin
            insn <= insn;
            pc   <= pc;
            run  <= run;
         end else if (skid_valid_s) begin
            insn <= skid_insn_s;
            pc   <= skid_pc_s;
            run  <= 1'b1;
         end else if (inflight_r) begin
            insn <= imem_rdata;
            pc   <= inflight_pc_r;
            run  <= 1'b1;
         end else begin
            insn <= NOP_INSN;
            pc   <= pc;
            run  <= 1'b0;
         end
      end
   end

   fetch_skid u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load_s),
      .clear     (skid_clear_s),
      .load_insn (imem_rdata),
      .load_pc   (inflight_pc_r),
      .valid     (skid_valid_s),
      .q_insn    (skid_insn_s),
      .q_pc      (skid_pc_s)
   );

   fetch_unit_chk u_chk (
      .clk        (clk),
      .reset      (reset),
      .skid_valid (skid_valid_s),
      .inflight   (inflight_r),
      .stall      (stall)
   );

endmodule
